// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD accumulator: FSM encoding, digit
// geometry and a digit-validity helper.
package bcd_pkg;

  localparam int         DIG_W    = 4;
  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam int         NDIG_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADD,
    ST_DONE
  } state_t;

  function automatic logic is_bcd(input logic [DIG_W-1:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/adder_bcd.sv
// One-digit BCD adder: binary add, then +6 correction when the raw sum
// exceeds 9. Non-BCD inputs produce a deterministic but meaningless result.
module adder_bcd
  import bcd_pkg::*;
(
  input  logic [DIG_W-1:0] a,
  input  logic [DIG_W-1:0] b,
  input  logic             cin,
  output logic [DIG_W-1:0] sum,
  output logic             cout
);

  logic [DIG_W:0] raw;

  always_comb begin
    raw  = {1'b0, a} + {1'b0, b} + {{DIG_W{1'b0}}, cin};
    cout = raw > {1'b0, BCD_MAX};
    sum  = cout ? raw[DIG_W-1:0] + 4'd6 : raw[DIG_W-1:0];
  end

endmodule

// File: rtl/bcd_serial_accum.sv
// Serial NDIG-digit BCD accumulator: one digit per clock through a single
// shared adder_bcd. Optional macro BCD_INVALID_CHECK_EN rejects non-BCD operands.
module bcd_serial_accum
  import bcd_pkg::*;
#(
  parameter int NDIG = NDIG_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIG_W*NDIG-1:0] operand,
  input  logic                  clear,
  output logic [DIG_W*NDIG-1:0] acc,
  output logic                  out_valid,
  output logic                  overflow,
  output logic                  err
);

  localparam int               IDX_W    = $clog2(NDIG);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

  state_t                       state, state_nxt;
  logic [NDIG-1:0][DIG_W-1:0]   acc_reg, work_reg, op_reg;
  logic [IDX_W-1:0]             idx;
  logic                         carry;
  logic                         ovf_reg;
  logic                         valid_reg;
  logic                         accept;
  logic                         last_digit;
  logic                         bad_reg;
  logic [DIG_W-1:0]             sum_d;
  logic                         cout_d;

  // The only adder; idx selects which digit pair it sees this cycle.
  adder_bcd u_adder (
    .a    (work_reg[idx]),
    .b    (op_reg[idx]),
    .cin  (carry),
    .sum  (sum_d),
    .cout (cout_d)
  );

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and a latch can never be inferred.
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    last_digit = (idx == IDX_LAST);
    case (state)
      ST_IDLE: begin
        in_ready = ~clear & ~rst;
        if (in_valid && in_ready) state_nxt = ST_ADD;
      end
      ST_ADD:  if (last_digit) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg   <= '0;
      work_reg  <= '0;
      op_reg    <= '0;
      idx       <= '0;
      carry     <= 1'b0;
      ovf_reg   <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clear) begin
            acc_reg <= '0;
            ovf_reg <= 1'b0;
          end else if (accept) begin
            op_reg   <= operand;
            work_reg <= acc_reg;
            idx      <= '0;
            carry    <= 1'b0;
          end
        end
        ST_ADD: begin
          work_reg[idx] <= sum_d;
          carry         <= cout_d;
          idx           <= idx + 1'b1;
          if (last_digit) valid_reg <= 1'b1;
        end
        ST_DONE: begin
          // Commit the whole total at once so readout never sees a partial sum.
          if (!bad_reg) begin
            acc_reg <= work_reg;
            ovf_reg <= ovf_reg | carry;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BCD_INVALID_CHECK_EN
  logic op_bad;
  logic err_reg;

  always_comb begin
    op_bad = 1'b0;
    for (int i = 0; i < NDIG; i++)
      if (!is_bcd(operand[i*DIG_W +: DIG_W])) op_bad = 1'b1;
  end

  // Invalid operands still run the full sequence to keep latency fixed.
  always_ff @(posedge clk) begin
    if (rst) begin
      bad_reg <= 1'b0;
      err_reg <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      if (state == ST_IDLE && accept)     bad_reg <= op_bad;
      if (state == ST_ADD  && last_digit) err_reg <= bad_reg;
    end
  end

  assign err = err_reg;
`else
  assign bad_reg = 1'b0;
  assign err     = 1'b0;
`endif

  assign acc       = acc_reg;
  assign overflow  = ovf_reg;
  assign out_valid = valid_reg;

endmodule

// File: doc/bcd_serial_accum.md
# bcd_serial_accum

Multi-digit BCD accumulator that adds a packed NDIG-digit BCD operand into a running BCD total, one digit per clock, through a single instance of the team's one-digit BCD adder. Sits directly upstream of that adder: it sequences digits and carries into it, collects its sum/carry outputs, and presents the updated total to display/readout logic.

## Interface
- NDIG, default 4: number of BCD digits in operand and accumulator (≥2).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand offered.
- in_ready  out  1  block can accept an operand this cycle.
- operand  in  4*NDIG  packed BCD operand; digit 0 at [3:0].
- clear  in  1  zero the accumulator and overflow flag (IDLE only).
- acc  out  4*NDIG  accumulated BCD total, digit 0 at [3:0].
- out_valid  out  1  one-cycle pulse; the add has completed and acc is updated.
- overflow  out  1  sticky; carry out of the top digit occurred since the last clear/reset.
- err  out  1  non-BCD operand rejected (valid with out_valid; tied 0 without macro).

## Operation
- States: IDLE, ADD, DONE.
- IDLE: in_ready = ~clear. clear=1 → acc <= 0, overflow <= 0; no operand accepted that cycle (clear wins over in_valid).
- Accept on in_valid & in_ready: latch operand into op_reg, copy acc into work_reg, digit index <= 0, carry <= 0, go to ADD.
- ADD, one digit per cycle: adder a = work_reg digit[idx], b = op_reg digit[idx], cin = carry; write sum into work_reg digit[idx], carry <= cout, idx++. After idx = NDIG-1 go to DONE.
- DONE: acc <= work_reg (atomic, never partially updated); overflow <= overflow | carry; out_valid = 1; return to IDLE.
- Arithmetic: result is (acc + operand) mod 10^NDIG; carry out of the top digit is only reported via overflow.
- clear, in_valid during ADD/DONE: ignored; in_ready = 0.
- Reset: state IDLE, acc = 0, overflow = 0, out_valid = 0, err = 0, internal regs 0; in_ready = 0 while rst is high, 1 in the first cycle after.
- Reset mid-ADD/DONE: operation abandoned, no out_valid, acc = 0.

## Timing
- Accept edge = cycle 0; ADD occupies cycles 1..NDIG; out_valid high in cycle NDIG+1, acc/overflow new values visible from cycle NDIG+2 (registered at end of DONE).
- in_ready returns high in cycle NDIG+2; throughput one operand per NDIG+2 cycles.
- out_valid and err are registered single-cycle pulses.

## Configuration
- BCD_INVALID_CHECK_EN defined: at accept, any operand digit > 9 marks the operation invalid; the ADD sequence still runs for fixed latency, but DONE leaves acc and overflow unchanged and pulses err together with out_valid.
- Not defined: no check; err tied 0; non-BCD digits pass straight to the adder and the result is whatever the adder's correction rule produces (deterministic, unspecified).

## Structure
- Shared package bcd_pkg: state encoding (IDLE/ADD/DONE), BCD_MAX = 9, digit width 4, NDIG default.
- One sub-module: the existing one-digit adder adder_bcd (a, b, cin → sum, cout), instantiated once and time-multiplexed; no second adder copy.

## Test plan
- Reset, then add 1234 to 0 (NDIG=4) → out_valid at cycle 5, acc = 1234, overflow = 0.
- acc = 0999, add 0001 → acc = 1000 (carry ripples across three digits), overflow = 0.
- acc = 9999, add 0002 → acc = 0001, overflow = 1; add 0001 → acc = 0002, overflow still 1; clear → acc = 0000, overflow = 0.
- clear and in_valid both high in IDLE → acc = 0, in_ready = 0 that cycle, operand not accepted, no out_valid.
- rst asserted in cycle 2 of an ADD → next cycle state IDLE, acc = 0, out_valid never pulses; in_ready = 1 after rst drops.
- With BCD_INVALID_CHECK_EN: acc = 0050, operand digits {1,2,A,4} → out_valid and err pulse at cycle 5, acc stays 0050; without the macro err stays 0 throughout.
